rom_dl_router: RTL and testbench

ROM_DL_ROUTER -- requirements
Module: rom_dl_router

---
 rtl/tp84_dl_pkg.sv | 38 +++
 rtl/dl_rgn_counter.sv | 47 ++++
 rtl/rom_dl_router.sv | 113 +++++++++++
 tb/tb_rom_dl_router.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tp84_dl_pkg.sv
// Shared types, FSM states and the TP-84 region map for the ROM download router.
// Region table entries are {base, size}; rgn_fits() is the elaboration-time non-wrap check.
package tp84_dl_pkg;

    typedef struct packed {
        logic [31:0] base;
        logic [31:0] size;
    } region_t;

    localparam int unsigned TP84_NUM_RGN = 17;

    typedef region_t [TP84_NUM_RGN-1:0] tp84_rgn_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } dl_state_t;

    function automatic tp84_rgn_t build_tp84_rgn();
        tp84_rgn_t t;
        t[0] = '{base: 32'h0000_0000, size: 32'h0000_2000};
        t[1] = '{base: 32'h0000_2000, size: 32'h0000_0040};
        t[2] = '{base: 32'h0000_2040, size: 32'h0000_0080};
        for (int unsigned i = 3; i < TP84_NUM_RGN; i++) begin
            t[i] = '{base: 32'h0000_20C0 + (i - 3) * 32'h40, size: 32'h0000_0040};
        end
        return t;
    endfunction

    // A region may end exactly at the top of the address space but never wrap past it.
    function automatic bit rgn_fits(region_t r, int unsigned addr_w);
        return ({32'h0, r.base} + {32'h0, r.size}) <= (64'd1 << addr_w);
    endfunction

    localparam tp84_rgn_t TP84_RGN = build_tp84_rgn();

endpackage

// File: rtl/dl_rgn_counter.sv
// Per-region saturating byte counter and done flag.
// The 8-bit additive checksum is built only when DL_CHECKSUM_EN is defined.
module dl_rgn_counter #(
    parameter int unsigned       ADDR_W = 25,
    parameter logic [ADDR_W:0]   SIZE   = '0
) (
    input  logic       clk_49m,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    input  logic [7:0] data,
    output logic       done,
    output logic [7:0] sum
);

    localparam logic [ADDR_W:0] ONE = 1;

    logic [ADDR_W:0] cnt;

    always_ff @(posedge clk_49m) begin
        if (!reset || clear) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            if (inc && cnt != SIZE) begin
                cnt <= cnt + ONE;
            end
            done <= (cnt == SIZE);
        end
    end

`ifdef DL_CHECKSUM_EN
    always_ff @(posedge clk_49m) begin
        if (!reset || clear) begin
            sum <= '0;
        end else if (inc) begin
            sum <= sum + data;
        end
    end
`else
    logic data_unused;

    assign sum         = '0;
    assign data_unused = ^data;
`endif

endmodule

// File: rtl/rom_dl_router.sv
// Routes ioctl download bytes to ROM regions, tracks per-region completion and misses.
// Define DL_CHECKSUM_EN to build the per-region checksum; otherwise rgn_sum reads zero.
module rom_dl_router
    import tp84_dl_pkg::*;
#(
    parameter int unsigned           NUM_RGN   = 17,
    parameter int unsigned           ADDR_W    = 25,
    parameter region_t [NUM_RGN-1:0] RGN_TABLE = TP84_RGN
) (
    input  logic                    clk_49m,
    input  logic                    reset,
    input  logic                    ioctl_download,
    input  logic [ADDR_W-1:0]       ioctl_addr,
    input  logic [7:0]              ioctl_data,
    input  logic                    ioctl_wr,
    output logic [NUM_RGN-1:0]      rgn_wr,
    output logic [ADDR_W-1:0]       rgn_addr,
    output logic [7:0]              rgn_data,
    output logic [NUM_RGN-1:0]      rgn_done,
    output logic                    all_done,
    output logic [7:0]              miss_cnt,
    output logic [NUM_RGN-1:0][7:0] rgn_sum
);

    dl_state_t state, state_next;

    logic                dl_q, wr_q;
    logic                dl_rise, dl_fall, load_entry, wr_acc, any_hit;
    logic [NUM_RGN-1:0]  hit_sel;
    logic [ADDR_W-1:0]   hit_off;

    // Edge samplers run through reset so a download held high at release is not a new session.
    always_ff @(posedge clk_49m) begin
        dl_q <= ioctl_download;
        wr_q <= ioctl_wr;
    end

    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;
    assign load_entry = (state != ST_LOAD) && dl_rise;
    assign wr_acc     = ioctl_wr && !wr_q && (state == ST_LOAD);

    always_ff @(posedge clk_49m) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (dl_rise) state_next = ST_LOAD;
            ST_LOAD:          if (dl_fall) state_next = ST_DONE;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Lowest-index region wins on overlap; the size compare is one bit wider so a full-space region works.
    always_comb begin
        hit_sel = '0;
        hit_off = '0;
        any_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_RGN; i++) begin
            if (!any_hit && ioctl_addr >= RGN_TABLE[i].base[ADDR_W-1:0]
                && {1'b0, ioctl_addr - RGN_TABLE[i].base[ADDR_W-1:0]} < RGN_TABLE[i].size[ADDR_W:0]) begin
                hit_sel[i] = 1'b1;
                hit_off    = ioctl_addr - RGN_TABLE[i].base[ADDR_W-1:0];
                any_hit    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_49m) begin
        if (!reset) begin
            rgn_wr   <= '0;
            rgn_addr <= '0;
            rgn_data <= '0;
            miss_cnt <= '0;
        end else begin
            rgn_wr <= wr_acc ? hit_sel : '0;
            if (wr_acc && any_hit) begin
                rgn_addr <= hit_off;
                rgn_data <= ioctl_data;
            end
            if (load_entry) begin
                miss_cnt <= '0;
            end else if (wr_acc && !any_hit && miss_cnt != 8'hFF) begin
                miss_cnt <= miss_cnt + 8'd1;
            end
        end
    end

    assign all_done = (state == ST_DONE) && (&rgn_done);

    for (genvar i = 0; i < NUM_RGN; i++) begin : g_rgn
        if (!rgn_fits(RGN_TABLE[i], ADDR_W)) begin : g_wrap
            $error("rom_dl_router: region %0d base+size exceeds the address space", i);
        end

        dl_rgn_counter #(
            .ADDR_W (ADDR_W),
            .SIZE   (RGN_TABLE[i].size[ADDR_W:0])
        ) u_cnt (
            .clk_49m (clk_49m),
            .reset   (reset),
            .clear   (load_entry),
            .inc     (wr_acc & hit_sel[i]),
            .data    (ioctl_data),
            .done    (rgn_done[i]),
            .sum     (rgn_sum[i])
        );
    end

endmodule

// File: tb/tb_rom_dl_router.sv
// Self-checking bench for rom_dl_router: vector table, directed corner sequences and
// randomized writes checked against a region-map reference model.
module tb_rom_dl_router;

    localparam int NR     = 17;
    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_DONE = 2;

    logic clk_49m = 1'b0;
    always #10 clk_49m = ~clk_49m;

    logic                reset;
    logic                ioctl_download;
    logic [24:0]         ioctl_addr;
    logic [7:0]          ioctl_data;
    logic                ioctl_wr;
    logic [NR-1:0]       rgn_wr;
    logic [24:0]         rgn_addr;
    logic [7:0]          rgn_data;
    logic [NR-1:0]       rgn_done;
    logic                all_done;
    logic [7:0]          miss_cnt;
    logic [NR-1:0][7:0]  rgn_sum;

    rom_dl_router #(
        .NUM_RGN (NR),
        .ADDR_W  (25)
    ) dut (
        .clk_49m        (clk_49m),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_addr     (ioctl_addr),
        .ioctl_data     (ioctl_data),
        .ioctl_wr       (ioctl_wr),
        .rgn_wr         (rgn_wr),
        .rgn_addr       (rgn_addr),
        .rgn_data       (rgn_data),
        .rgn_done       (rgn_done),
        .all_done       (all_done),
        .miss_cnt       (miss_cnt),
        .rgn_sum        (rgn_sum)
    );

    int checks = 0;
    int errors = 0;

    int         mbase [NR];
    int         msize [NR];
    int         mcnt  [NR];
    logic [7:0] msum  [NR];
    int         mmiss;
    int         mstate;

    int pulse_cnt [NR] = '{default: 0};

    always @(negedge clk_49m) begin
        for (int i = 0; i < NR; i++) begin
            if (rgn_wr[i]) pulse_cnt[i]++;
        end
    end

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        int          hold;
        int          rgn;
        logic [24:0] off;
    } vec_t;

    vec_t vt [11];

    task automatic tick();
        @(posedge clk_49m);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int find_rgn(input logic [24:0] a);
        for (int i = 0; i < NR; i++) begin
            if (int'(a) >= mbase[i] && int'(a) < mbase[i] + msize[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_done();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = (mcnt[i] == msize[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            mcnt[i] = 0;
            msum[i] = 8'h00;
        end
        mmiss  = 0;
        mstate = M_IDLE;
    endtask

    task automatic model_apply(input logic [24:0] a, input logic [7:0] d, output int idx);
        if (mstate != M_LOAD) begin
            idx = -2;
        end else begin
            idx = find_rgn(a);
            if (idx >= 0) begin
                if (mcnt[idx] < msize[idx]) mcnt[idx]++;
                msum[idx] = msum[idx] + d;
            end else if (mmiss < 255) begin
                mmiss++;
            end
        end
    endtask

    task automatic check_state(input string tag);
        logic [NR-1:0] ed;
        logic [7:0]    es;
        ed = exp_done();
        chk({tag, " rgn_done"}, 64'(rgn_done), 64'(ed));
        chk({tag, " miss_cnt"}, 64'(miss_cnt), 64'(mmiss));
        chk({tag, " all_done"}, 64'(all_done), 64'(mstate == M_DONE && (&ed)));
        for (int i = 0; i < NR; i++) begin
`ifdef DL_CHECKSUM_EN
            es = msum[i];
`else
            es = 8'h00;
`endif
            chk({tag, " rgn_sum"}, 64'(rgn_sum[i]), 64'(es));
        end
    endtask

    // One ioctl write: wr held for 'hold' cycles, then one low cycle; drop lowers download with the strobe.
    task automatic do_write(input logic [24:0] a, input logic [7:0] d, input int hold, input bit drop,
                            output logic [NR-1:0] g_wr, output logic [24:0] g_addr,
                            output logic [7:0] g_data, output int extra);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        if (drop) ioctl_download = 1'b0;
        tick();
        g_wr   = rgn_wr;
        g_addr = rgn_addr;
        g_data = rgn_data;
        extra  = 0;
        for (int k = 1; k < hold; k++) begin
            tick();
            if (rgn_wr != '0) extra++;
        end
        ioctl_wr = 1'b0;
        tick();
        if (rgn_wr != '0) extra++;
    endtask

    task automatic mwrite(input logic [24:0] a, input logic [7:0] d, input int hold, input bit drop);
        int            idx;
        int            extra;
        logic [NR-1:0] gw, ew;
        logic [24:0]   ga;
        logic [7:0]    gd;
        model_apply(a, d, idx);
        do_write(a, d, hold, drop, gw, ga, gd, extra);
        ew = '0;
        if (idx >= 0) ew[idx] = 1'b1;
        chk("wr_pulse", 64'(gw), 64'(ew));
        chk("held_pulses", 64'(extra), 64'd0);
        if (idx >= 0) begin
            chk("rgn_addr", 64'(ga), 64'(25'(int'(a) - mbase[idx])));
            chk("rgn_data", 64'(gd), 64'(d));
        end
        if (drop && mstate == M_LOAD) mstate = M_DONE;
    endtask

    task automatic start_session();
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) begin
            mcnt[i] = 0;
            msum[i] = 8'h00;
        end
        mmiss  = 0;
        mstate = M_LOAD;
        tick();
    endtask

    task automatic end_session();
        ioctl_download = 1'b0;
        tick();
        if (mstate == M_LOAD) mstate = M_DONE;
        tick();
    endtask

    initial begin
        int            idx, extra, p0, j;
        logic [NR-1:0] gw, ew;
        logic [24:0]   ga, a;
        logic [7:0]    gd;

        mbase[0] = 'h0000; msize[0] = 'h2000;
        mbase[1] = 'h2000; msize[1] = 'h40;
        mbase[2] = 'h2040; msize[2] = 'h80;
        for (int i = 3; i < NR; i++) begin
            mbase[i] = 'h20C0 + (i - 3) * 'h40;
            msize[i] = 'h40;
        end

        vt[0]  = '{25'h0002005, 8'hA5, 4,  1, 25'h0005};
        vt[1]  = '{25'h0000000, 8'h11, 1,  0, 25'h0000};
        vt[2]  = '{25'h0001FFF, 8'h22, 2,  0, 25'h1FFF};
        vt[3]  = '{25'h0002000, 8'h33, 1,  1, 25'h0000};
        vt[4]  = '{25'h000203F, 8'h44, 3,  1, 25'h003F};
        vt[5]  = '{25'h0002040, 8'h55, 1,  2, 25'h0000};
        vt[6]  = '{25'h00020BF, 8'h66, 1,  2, 25'h007F};
        vt[7]  = '{25'h00020C0, 8'h77, 2,  3, 25'h0000};
        vt[8]  = '{25'h000243F, 8'h88, 1, 16, 25'h003F};
        vt[9]  = '{25'h0002440, 8'h99, 1, -1, 25'h0000};
        vt[10] = '{25'h1FFFFFF, 8'hAA, 2, -1, 25'h0000};

        reset          = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_data     = '0;
        model_reset();
        repeat (3) tick();
        chk("reset rgn_wr", 64'(rgn_wr), 64'd0);
        chk("reset rgn_addr", 64'(rgn_addr), 64'd0);
        chk("reset rgn_data", 64'(rgn_data), 64'd0);
        check_state("reset");

        reset = 1'b1;
        tick();
        mwrite(25'h0000010, 8'h5A, 1, 1'b0);

        // Vector table inside one session
        start_session();
        for (int k = 0; k < 11; k++) begin
            model_apply(vt[k].addr, vt[k].data, idx);
            do_write(vt[k].addr, vt[k].data, vt[k].hold, 1'b0, gw, ga, gd, extra);
            ew = '0;
            if (vt[k].rgn >= 0) ew[vt[k].rgn] = 1'b1;
            chk("vec wr_pulse", 64'(gw), 64'(ew));
            chk("vec held_pulses", 64'(extra), 64'd0);
            if (vt[k].rgn >= 0) begin
                chk("vec rgn_addr", 64'(ga), 64'(vt[k].off));
                chk("vec rgn_data", 64'(gd), 64'(vt[k].data));
            end
        end
        check_state("vectors");

        // Unmapped address hammered past miss saturation
        for (int k = 0; k < 300; k++) mwrite(25'h1FFFFFF, 8'($urandom), 1, 1'b0);
        chk("miss_cnt saturated", 64'(miss_cnt), 64'd255);
        check_state("miss");

        // Checksum wrap on region 1
        end_session();
        start_session();
        mwrite(25'h0002000, 8'hFF, 1, 1'b0);
        mwrite(25'h0002001, 8'h02, 1, 1'b0);
`ifdef DL_CHECKSUM_EN
        chk("rgn_sum[1] wrap", 64'(rgn_sum[1]), 64'h01);
`else
        chk("rgn_sum[1] disabled", 64'(rgn_sum[1]), 64'h00);
`endif
        check_state("checksum");

        // Full load; the final byte coincides with download falling
        end_session();
        start_session();
        p0 = pulse_cnt[0];
        for (int k = 0; k < 'h2000; k++) mwrite(25'(k), 8'($urandom), 1, 1'b0);
        chk("rgn_done[0] after last", 64'(rgn_done[0]), 64'd1);
        chk("rgn_wr[0] pulse count", 64'(pulse_cnt[0] - p0), 64'd8192);
        for (int k = 'h2000; k < 'h2440; k++) mwrite(25'(k), 8'($urandom), 1, k == 'h243F);
        end_session();
        chk("all_done full", 64'(all_done), 64'd1);
        check_state("full");
        mwrite(25'h0002041, 8'h3C, 1, 1'b0);
        check_state("done ignores writes");

        // One byte short
        start_session();
        for (int k = 0; k < 'h243F; k++) mwrite(25'(k), 8'($urandom), 1, 1'b0);
        end_session();
        chk("all_done short", 64'(all_done), 64'd0);
        check_state("short");

        // Randomized session
        start_session();
        for (int n = 0; n < 1500; n++) begin
            j = $urandom_range(0, 9);
            if (j < 7) begin
                a = 25'($urandom_range(0, 'h24FF));
            end else if (j < 9) begin
                a = 25'($urandom);
            end else begin
                j = $urandom_range(0, NR - 1);
                a = ($urandom_range(0, 1) == 1) ? 25'(mbase[j]) : 25'(mbase[j] + msize[j] - 1);
            end
            mwrite(a, 8'($urandom), $urandom_range(1, 3), 1'b0);
        end
        check_state("random");
        end_session();
        check_state("random end");

        // Reset in the middle of region 2
        start_session();
        for (int k = 0; k < 100; k++) mwrite(25'('h2040 + k), 8'hC3, 1, 1'b0);
        reset = 1'b0;
        tick();
        model_reset();
        chk("midreset rgn_wr", 64'(rgn_wr), 64'd0);
        chk("midreset rgn_addr", 64'(rgn_addr), 64'd0);
        chk("midreset rgn_data", 64'(rgn_data), 64'd0);
        check_state("midreset");
        reset = 1'b1;
        tick();
        mwrite(25'h00020A4, 8'h12, 1, 1'b0);
        mwrite(25'h0000000, 8'h34, 2, 1'b0);
        check_state("after release");
        ioctl_download = 1'b0;
        tick();
        start_session();
        mwrite(25'h0002040, 8'h56, 1, 1'b0);
        check_state("new session");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
